// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory read port, branch redirect and the IF/ID handshake.
// The master modport belongs to the fetch queue. The slave modport belongs to the memory/ID side.
interface fetch_queue_if #(
    parameter int ADDR_W = 10
);
    // IF/ID handshake: a word transfers on a rising edge where if_valid && if_ready && !redirect.
    // if_valid never depends combinationally on if_ready. A held head keeps if_instr/if_pc4 stable.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              if_ready;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc4;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc4,
        input  imem_rdata, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc4,
        output imem_rdata, redirect, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: generates fetch PCs, reads a 1-cycle instruction memory and buffers words for IF/ID.
// Optional macro FETCHQ_STATS_EN adds the saturating stat_bubbles counter output.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus,
    output logic          o_dbg_state
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]   stat_bubbles
`endif
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {ST_BOOT = 1'b0, ST_FETCH = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic             r_inflight_epoch;
    logic             r_epoch;
    logic [31:0]      r_instr_mem [DEPTH];
    logic [31:0]      r_pc4_mem   [DEPTH];

    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [PTR_W:0]   w_occupancy;

    // Counting the in-flight word reserves its slot, so a response can never overflow the buffer.
    assign w_occupancy = r_count + {{PTR_W{1'b0}}, r_inflight};
    assign w_valid     = (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                w_state_nxt = ST_FETCH;
                w_issue     = !bus.redirect && (w_occupancy < DEPTH_C);
            end
            default:  w_state_nxt = ST_BOOT;
        endcase
        w_push = r_inflight && (r_inflight_epoch == r_epoch) && !bus.redirect;
        w_pop  = w_valid && bus.if_ready && !bus.redirect;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_BOOT;
            r_fetch_pc       <= RESET_PC;
            r_count          <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_inflight       <= 1'b0;
            r_inflight_pc    <= '0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc    <= r_fetch_pc;
                r_inflight_epoch <= r_epoch;
            end
            if (bus.redirect) begin
                // Flipping the epoch orphans any word already requested under the old path.
                r_fetch_pc <= bus.redirect_pc & ~32'h3;
                r_epoch    <= ~r_epoch;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_issue)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + (PTR_W + 1)'(1);
                else if (!w_push && w_pop)
                    r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pc4_mem[r_wr_ptr]   <= r_inflight_pc + 32'd4;
        end
    end

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = (r_state == ST_FETCH) ? r_fetch_pc[ADDR_W+1:2] : '0;
    assign bus.if_valid  = w_valid;
    assign bus.if_instr  = w_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
    assign bus.if_pc4    = w_valid ? r_pc4_mem[r_rd_ptr] : 32'h0;
    assign o_dbg_state   = (r_state == ST_FETCH);

`ifdef FETCHQ_STATS_EN
    logic [31:0] r_bubbles;

    // A bubble is a cycle where IF/ID could take a word but none is ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_bubbles <= '0;
        else if ((r_state == ST_FETCH) && bus.if_ready && !w_valid && !bus.redirect &&
                 (r_bubbles != 32'hFFFF_FFFF))
            r_bubbles <= r_bubbles + 32'd1;
    end

    assign stat_bubbles = r_bubbles;
`endif
endmodule
